// File: rtl/vic_raster_timer.sv
// Beam position and bus timing for the PAL VIC-II: dot/cycle/line counters, phi0,
// raster-compare IRQ and bad-line flag. All outputs registered, no backpressure.
module vic_raster_timer #(
    parameter int DOTS_PER_CYCLE  = 8,
    parameter int CYCLES_PER_LINE = 63,
    parameter int LINES_PER_FRAME = 312
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_dotEn,
    input  logic [8:0] i_cmpValue,
    input  logic       i_cmpWe,
    input  logic       i_irqAck,
    input  logic [2:0] i_yscroll,
    input  logic       i_den,
    output logic       o_phi0,
    output logic       o_phi0Rise,
    output logic [2:0] o_dot,
    output logic [5:0] o_cycle,
    output logic [8:0] o_xpos,
    output logic [8:0] o_rasterLine,
    output logic       o_lineStart,
    output logic       o_frameStart,
    output logic       o_irq,
    output logic       o_badLine
);
    localparam logic [2:0] DOT_LAST  = 3'(DOTS_PER_CYCLE - 1);
    localparam logic [2:0] DOT_HALF  = 3'(DOTS_PER_CYCLE / 2);
    localparam logic [5:0] CYC_LAST  = 6'(CYCLES_PER_LINE - 1);
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] DEN_LINE  = 9'h030;
    localparam logic [8:0] BAD_FIRST = 9'h030;
    localparam logic [8:0] BAD_LAST  = 9'h0F7;

    logic [2:0] dot_q, dot_d;
    logic [5:0] cycle_q, cycle_d;
    logic [8:0] line_q, line_d;
    logic [8:0] cmp_q;
    logic       den_q, den_d;
    logic       dot_wrap, cyc_wrap, line_inc, line_wrap;
    logic       irq_set;

    always_comb begin
        dot_wrap  = (dot_q == DOT_LAST);
        cyc_wrap  = dot_wrap && (cycle_q == CYC_LAST);
        line_inc  = i_dotEn && cyc_wrap;
        line_wrap = line_inc && (line_q == LINE_LAST);

        dot_d   = dot_q;
        cycle_d = cycle_q;
        line_d  = line_q;
        if (i_dotEn) begin
            dot_d = dot_wrap ? 3'd0 : dot_q + 3'd1;
            if (dot_wrap)
                cycle_d = cyc_wrap ? 6'd0 : cycle_q + 6'd1;
            if (cyc_wrap)
                line_d = (line_q == LINE_LAST) ? 9'd0 : line_q + 9'd1;
        end

        // DEN is sampled on every clk of line 0x30, not only on dot enables
        den_d = den_q;
        if (line_wrap)
            den_d = 1'b0;
        else if (line_q == DEN_LINE && i_den)
            den_d = 1'b1;

        // Compare against the pre-write register; a rewrite of the same value is silent
        irq_set = (line_inc && line_d == cmp_q)
               || (i_cmpWe && i_cmpValue == line_q && i_cmpValue != cmp_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dot_q        <= '0;
            cycle_q      <= '0;
            line_q       <= '0;
            cmp_q        <= '0;
            den_q        <= 1'b0;
            o_phi0       <= 1'b0;
            o_phi0Rise   <= 1'b0;
            o_xpos       <= '0;
            o_lineStart  <= 1'b0;
            o_frameStart <= 1'b0;
            o_irq        <= 1'b0;
            o_badLine    <= 1'b0;
        end else begin
            dot_q        <= dot_d;
            cycle_q      <= cycle_d;
            line_q       <= line_d;
            den_q        <= den_d;
            if (i_cmpWe)
                cmp_q <= i_cmpValue;
            o_phi0       <= (dot_d >= DOT_HALF);
            o_phi0Rise   <= i_dotEn && (dot_d == DOT_HALF);
            o_xpos       <= 9'(cycle_d) * 9'(DOTS_PER_CYCLE) + 9'(dot_d);
            o_lineStart  <= line_inc;
            o_frameStart <= line_wrap;
            if (irq_set)
                o_irq <= 1'b1;
            else if (i_irqAck)
                o_irq <= 1'b0;
            o_badLine    <= (line_d >= BAD_FIRST) && (line_d <= BAD_LAST)
                         && (line_d[2:0] == i_yscroll)
                         && (den_d || (i_den && line_d == DEN_LINE));
        end
    end

    assign o_dot        = dot_q;
    assign o_cycle      = cycle_q;
    assign o_rasterLine = line_q;

endmodule

// File: tb/tb_vic_raster_timer.sv
// Randomised and directed bench for vic_raster_timer against a dot-count reference model.
module tb_vic_raster_timer;
    localparam int DOTS       = 8;
    localparam int CYCS       = 4;
    localparam int LINES      = 312;
    localparam int LINE_DOTS  = DOTS * CYCS;
    localparam int FRAME_DOTS = LINE_DOTS * LINES;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_dotEn = 1'b0;
    logic [8:0] i_cmpValue = '0;
    logic       i_cmpWe = 1'b0;
    logic       i_irqAck = 1'b0;
    logic [2:0] i_yscroll = '0;
    logic       i_den = 1'b0;
    logic       o_phi0, o_phi0Rise, o_lineStart, o_frameStart, o_irq, o_badLine;
    logic [2:0] o_dot;
    logic [5:0] o_cycle;
    logic [8:0] o_xpos, o_rasterLine;

    vic_raster_timer #(
        .DOTS_PER_CYCLE (DOTS),
        .CYCLES_PER_LINE(CYCS),
        .LINES_PER_FRAME(LINES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_dotEn     (i_dotEn),
        .i_cmpValue  (i_cmpValue),
        .i_cmpWe     (i_cmpWe),
        .i_irqAck    (i_irqAck),
        .i_yscroll   (i_yscroll),
        .i_den       (i_den),
        .o_phi0      (o_phi0),
        .o_phi0Rise  (o_phi0Rise),
        .o_dot       (o_dot),
        .o_cycle     (o_cycle),
        .o_xpos      (o_xpos),
        .o_rasterLine(o_rasterLine),
        .o_lineStart (o_lineStart),
        .o_frameStart(o_frameStart),
        .o_irq       (o_irq),
        .o_badLine   (o_badLine)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Model: the beam position is a single dot count since frame start
    int m_n, m_cmp;
    bit m_irq, m_den, m_bad, m_rise, m_ls, m_fs;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_n = 0; m_cmp = 0;
        m_irq = 0; m_den = 0; m_bad = 0; m_rise = 0; m_ls = 0; m_fs = 0;
    endfunction

    function automatic void model_step();
        int old_line = m_n / LINE_DOTS;
        int ln;
        bit set = 0;
        m_rise = 0; m_ls = 0; m_fs = 0;
        if (i_dotEn) begin
            m_n = (m_n + 1) % FRAME_DOTS;
            m_rise = (m_n % DOTS) == DOTS / 2;
            if (m_n % LINE_DOTS == 0) begin
                m_ls = 1;
                m_fs = (m_n == 0);
                if (m_n / LINE_DOTS == m_cmp) set = 1;
            end
        end
        if (i_cmpWe && int'(i_cmpValue) == old_line && int'(i_cmpValue) != m_cmp) set = 1;
        if (i_cmpWe) m_cmp = int'(i_cmpValue);
        if (m_fs) m_den = 0;
        else if (old_line == 'h30 && i_den) m_den = 1;
        if (set) m_irq = 1;
        else if (i_irqAck) m_irq = 0;
        ln = m_n / LINE_DOTS;
        m_bad = ln >= 'h30 && ln <= 'hF7 && (ln % 8) == int'(i_yscroll)
             && (m_den || (i_den && ln == 'h30));
    endfunction

    function automatic int outs_sum();
        return int'(o_phi0) + int'(o_phi0Rise) + int'(o_dot) + int'(o_cycle) + int'(o_xpos)
             + int'(o_rasterLine) + int'(o_lineStart) + int'(o_frameStart) + int'(o_irq)
             + int'(o_badLine);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        int ed, ec, el, ex;
        bit ep;
        if (check_en) begin
            ed = m_n % DOTS;
            ec = (m_n / DOTS) % CYCS;
            el = m_n / LINE_DOTS;
            ex = m_n % LINE_DOTS;
            ep = (ed >= DOTS / 2);
            n_checks++;
            if (int'(o_dot) == ed && int'(o_cycle) == ec && int'(o_xpos) == ex
                && int'(o_rasterLine) == el && o_phi0 == ep && o_phi0Rise == m_rise
                && o_lineStart == m_ls && o_frameStart == m_fs && o_irq == m_irq
                && o_badLine == m_bad)
                n_pass++;
            else
                $display("FAIL outputs @%0t: dut dot=%0d cyc=%0d x=%0d line=%0d phi0=%0b rise=%0b ls=%0b fs=%0b irq=%0b bad=%0b; model dot=%0d cyc=%0d x=%0d line=%0d phi0=%0b rise=%0b ls=%0b fs=%0b irq=%0b bad=%0b",
                         $time, o_dot, o_cycle, o_xpos, o_rasterLine, o_phi0, o_phi0Rise,
                         o_lineStart, o_frameStart, o_irq, o_badLine,
                         ed, ec, ex, el, ep, m_rise, m_ls, m_fs, m_irq, m_bad);
        end
    end

    initial begin
        int bad_cnt, pos0, pos1, guard;
        model_reset();
        #12;
        check("reset_all_zero", outs_sum(), 0);
        @(negedge clk);
        reset = 1'b0;
        check_en = 1'b1;

        // Frame 1: continuous dot enable, compare/ack sequence, bad lines with DEN on
        i_dotEn = 1'b1; i_den = 1'b1; i_yscroll = 3'd3;
        for (int k = 1; k <= FRAME_DOTS; k++) begin
            i_cmpWe    = (k == 5 || k == 2180 || k == 2190);
            i_cmpValue = (k == 5) ? 9'h040 : 9'h044;
            i_irqAck   = (k == 2100 || k == 2180 || k == 2185);
            tick();
            case (k)
                3:          check("phi0_low_dot3", o_phi0, 0);
                4:          begin check("phi0_rise_dot4", o_phi0Rise, 1); check("dot_is_4", o_dot, 4);
                                  check("phi0_high_dot4", o_phi0, 1); end
                7:          check("phi0_high_dot7", o_phi0, 1);
                8:          begin check("phi0_low_after_wrap", o_phi0, 0); check("dot_wrap", o_dot, 0); end
                LINE_DOTS:  begin check("first_line_start", o_lineStart, 1); check("line_is_1", o_rasterLine, 1); end
                2047:       check("irq_before_cmp_line", o_irq, 0);
                2048:       begin check("irq_at_line_40", o_irq, 1); check("line_is_40", o_rasterLine, 'h40); end
                2099:       check("irq_held", o_irq, 1);
                2100:       check("irq_acked", o_irq, 0);
                2180:       check("set_wins_over_ack", o_irq, 1);
                2185:       check("irq_acked_again", o_irq, 0);
                2190:       check("rewrite_same_no_irq", o_irq, 0);
                1642:       check("badline_33", o_badLine, 1);
                1674:       check("no_badline_34", o_badLine, 0);
                7786:       check("badline_F3", o_badLine, 1);
                8042:       check("no_badline_FB", o_badLine, 0);
                FRAME_DOTS: begin check("frame_start", o_frameStart, 1); check("frame_line0", o_rasterLine, 0); end
                default: ;
            endcase
        end
        i_cmpWe = 1'b0; i_irqAck = 1'b0;

        // Frame 2: DEN low throughout, so no bad lines; compare still fires at 0x44
        i_den = 1'b0; bad_cnt = 0;
        for (int k = 1; k <= FRAME_DOTS; k++) begin
            tick();
            if (o_badLine) bad_cnt++;
            if (k == 'h44 * LINE_DOTS) check("irq_next_frame", o_irq, 1);
        end
        check("no_badlines_den0", bad_cnt, 0);

        // Randomised traffic with sparse dot enables
        for (int k = 0; k < 8000; k++) begin
            i_dotEn    = ($urandom_range(0, 3) != 0);
            i_cmpWe    = ($urandom_range(0, 199) == 0);
            i_cmpValue = ($urandom_range(0, 1) == 0) ? 9'(m_n / LINE_DOTS) : 9'($urandom_range(0, LINES - 1));
            i_irqAck   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 499) == 0) i_yscroll = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) i_den = ~i_den;
            tick();
        end
        i_cmpWe = 1'b0; i_irqAck = 1'b0;

        // Quarter-rate dot enable
        pos0 = int'(o_rasterLine) * LINE_DOTS + int'(o_xpos);
        for (int k = 0; k < 2000; k++) begin
            i_dotEn = (k % 4 == 0);
            tick();
        end
        pos1 = int'(o_rasterLine) * LINE_DOTS + int'(o_xpos);
        check("quarter_rate_advance", (pos1 - pos0 + FRAME_DOTS) % FRAME_DOTS, 500);

        // Run to line 0x100, cycle 2, raise the IRQ, then reset asynchronously
        i_dotEn = 1'b1; guard = 0;
        while (!(m_n / LINE_DOTS == 'h100 && (m_n / DOTS) % CYCS == 2) && guard < 20000) begin
            tick();
            guard++;
        end
        check("reach_line_100", o_rasterLine, 'h100);
        i_dotEn = 1'b0;
        i_cmpWe = 1'b1; i_cmpValue = 9'h0FF; tick();
        i_cmpValue = 9'h100; tick();
        i_cmpWe = 1'b0;
        check("irq_before_reset", o_irq, 1);
        @(posedge clk);
        #3;
        check_en = 1'b0;
        reset = 1'b1;
        #1;
        check("async_reset_all_zero", outs_sum(), 0);
        check("async_reset_irq", o_irq, 0);
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b0;
        check_en = 1'b1;

        // Restart from zero; compare register is 0, so the IRQ waits for the wrap into line 0
        i_dotEn = 1'b1;
        tick();
        check("restart_dot1", o_dot, 1);
        check("restart_cycle0", o_cycle, 0);
        check("restart_line0", o_rasterLine, 0);
        for (int k = 2; k <= FRAME_DOTS; k++) begin
            tick();
            if (k == FRAME_DOTS - 1) check("no_irq_before_wrap", o_irq, 0);
            if (k == FRAME_DOTS) begin
                check("irq_at_wrap_cmp0", o_irq, 1);
                check("frame_start_after_reset", o_frameStart, 1);
            end
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vic_raster_timer.md
Name: vic_raster_timer

Overview:
Beam-position and bus-timing generator for the 6569 (PAL) VIC-II core. It counts the dot-clock enable into 8-dot CPU cycles, 63-cycle lines and 312-line frames. From these counts it derives the phi0 CPU clock, the raster position, the raster-compare interrupt and the bad-line flag. The video core consumes its outputs to schedule pixel generation and memory fetches.

Parameters:
DOTS_PER_CYCLE, 8, dot enables per phi0 cycle; must be even.
CYCLES_PER_LINE, 63, phi0 cycles per raster line.
LINES_PER_FRAME, 312, raster lines per frame.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
i_dotEn  input  1  one-clk pulse per pixel (dot)
i_cmpValue  input  9  raster compare value
i_cmpWe  input  1  write strobe for i_cmpValue
i_irqAck  input  1  clears the raster IRQ flag
i_yscroll  input  3  vertical fine scroll
i_den  input  1  display enable bit
o_phi0  output  1  CPU clock level
o_phi0Rise  output  1  one-clk strobe on the rising edge of phi0
o_dot  output  3  dot index within the cycle
o_cycle  output  6  cycle index, 0..62
o_xpos  output  9  cycle*8+dot, 0..503
o_rasterLine  output  9  current line, 0..311
o_lineStart  output  1  one-clk strobe at line start
o_frameStart  output  1  one-clk strobe at frame start
o_irq  output  1  raster IRQ flag
o_badLine  output  1  current line is a bad line

Behaviour:
- Reset (async, any time, including mid-line): all counters 0, compare register 0, all flags and strobes 0, o_phi0 0.
- All state advances only on clk edges with i_dotEn=1. When i_dotEn=0 every registered output holds, and strobes are 0.
- All outputs are registered and reflect the state after the edge.
- Dot counter: 0..DOTS_PER_CYCLE-1, wraps to 0.
  - o_phi0 = 1 when dot >= DOTS_PER_CYCLE/2.
  - o_phi0Rise pulses on the edge where dot becomes DOTS_PER_CYCLE/2.
- Cycle counter: increments on dot wrap; after CYCLES_PER_LINE-1 it wraps to 0.
- Line counter: increments on cycle wrap; after LINES_PER_FRAME-1 it wraps to 0.
- o_xpos is derived from the registered counters.
- o_lineStart pulses on the edge where cycle and dot both become 0.
- o_frameStart pulses on that same edge when the line also becomes 0.
- Compare register: loaded from i_cmpValue on i_cmpWe. i_dotEn is irrelevant to the load.
- IRQ set conditions:
  - (a) on the line-increment edge, the new line equals the compare register;
  - (b) on i_cmpWe, the written value equals the current line and differs from the old compare value.
- When set, o_irq is 1 after that edge; no other latency is allowed.
- o_irq remains set until i_irqAck.
- If set and ack occur on the same edge, set wins.
- Reset does not create an IRQ. With compare=0, the first IRQ occurs at the next wrap into line 0.
- DEN latch:
  - Cleared on the edge entering line 0.
  - Set on any edge during line 0x30 where i_den=1.
- o_badLine = line in 0x30..0xF7 inclusive, AND line[2:0]==i_yscroll, AND (DEN latch set, or i_den while line==0x30).
  - o_badLine is re-evaluated every clk, independent of i_dotEn, so an i_yscroll change takes effect one clk later.

Test Plan:
- Reset, then hold i_dotEn=1 -> o_phi0 low for 4 clks and high for 4. o_phi0Rise at dot=4. After 504 clks, o_lineStart and line=1. After 157248 clks, o_frameStart and line=0.
- i_dotEn pulsing every 4th clk -> all counts advance at exactly 1/4 rate. Outputs are stable between pulses and strobes are never wider than 1 clk.
- Write cmp=0x040 at line 0 -> o_irq rises on the edge where line becomes 0x040. It stays high until i_irqAck. Ack and a new set on the same clk -> o_irq stays 1.
- At line 0x0A, with cmp=0x000, write cmp=0x00A -> o_irq is 1 on the next clk. Rewriting 0x00A while o_irq is cleared -> no IRQ.
- i_den=1 during line 0x30, yscroll=3 -> o_badLine on lines 0x33, 0x3B ... 0xF3 and not on 0xFB. i_den=0 throughout line 0x30 -> no bad lines that frame.
- Assert reset at line 0x100, cycle 30, with o_irq=1 -> all outputs 0 immediately, without waiting for a clock edge. After release, counting restarts from line 0, cycle 0, dot 0.
